// File: rtl/etm_div32by16_seq.sv
// Sequential restoring divider, 32b / 16b -> 16b quotient.
// Small dividends divide exactly; larger ones iterate only the upper quotient
// bits and fill the low field with a midpoint estimate, mirroring the ETM
// multiplier's exact/approximate split.
module etm_div32by16_seq #(
  parameter int APPROX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        exact,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] LAST_APPROX = 4'(APPROX_BITS);

  state_t      state_q, state_d;
  logic [15:0] dvd_lo_q, dvd_lo_d;   // only the low half is shifted in
  logic [15:0] dvs_q, dvs_d;
  logic [15:0] r_q, r_d;             // partial remainder, always < divisor between steps
  logic [15:0] q_q, q_d;
  logic [3:0]  idx_q, idx_d;         // quotient bit being resolved this cycle
  logic        approx_q, approx_d;
  logic [15:0] rem_q, rem_d;
  logic        exact_q, exact_d;
  logic        dbz_q, dbz_d;
  logic        ovf_q, ovf_d;

  logic [16:0] r_shift, r_next;
  logic        r_ge;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    r_shift = {r_q, dvd_lo_q[idx_q]};
    r_ge    = (r_shift >= {1'b0, dvs_q});
    r_next  = r_ge ? (r_shift - {1'b0, dvs_q}) : r_shift;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    dvd_lo_d = dvd_lo_q;
    dvs_d    = dvs_q;
    r_d      = r_q;
    q_d      = q_q;
    idx_d    = idx_q;
    approx_d = approx_q;
    rem_d    = rem_q;
    exact_d  = exact_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_lo_d = dividend[15:0];
          dvs_d    = divisor;
          q_d      = '0;
          rem_d    = '0;
          exact_d  = 1'b0;
          dbz_d    = 1'b0;
          ovf_d    = 1'b0;
          idx_d    = 4'd15;
          approx_d = 1'b0;
          if (divisor == 16'd0) begin
            q_d     = 16'hFFFF;
            rem_d   = dividend[15:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (dividend[31:16] >= divisor) begin
            q_d     = 16'hFFFF;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            r_d      = dividend[31:16];
            approx_d = (dividend[31:16] != 16'd0);
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        r_d        = r_next[15:0];
        q_d[idx_q] = r_ge;
        idx_d      = idx_q - 4'd1;
        if (idx_q == (approx_q ? LAST_APPROX : 4'd0)) begin
          state_d = DONE;
          if (approx_q) begin
            // Low field left zero except its MSB, which flags a nonzero residue.
            q_d[APPROX_BITS-1] = (r_next != 17'd0);
            rem_d   = '0;
            exact_d = 1'b0;
          end else begin
            rem_d   = r_next[15:0];
            exact_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dvd_lo_q <= '0;
      dvs_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      idx_q    <= '0;
      approx_q <= 1'b0;
      rem_q    <= '0;
      exact_q  <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_lo_q <= dvd_lo_d;
      dvs_q    <= dvs_d;
      r_q      <= r_d;
      q_q      <= q_d;
      idx_q    <= idx_d;
      approx_q <= approx_d;
      rem_q    <= rem_d;
      exact_q  <= exact_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = rem_q;
  assign exact       = exact_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_etm_div32by16_seq.sv
// Scoreboard bench for etm_div32by16_seq with APPROX_BITS=4.
module tb_etm_div32by16_seq;

  localparam int AB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] dividend;
  logic [15:0] divisor, quotient, remainder;
  logic        exact, div_by_zero, overflow;

  typedef struct {
    logic [50:0] res;   // {q, r, exact, dbz, ovf}
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  etm_div32by16_seq #(.APPROX_BITS(AB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .exact(exact), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] dvd, input logic [15:0] dvs);
    exp_t e;
    logic [31:0] qf, rr;
    if (dvs == 0) begin
      e.res = {16'hFFFF, dvd[15:0], 3'b010}; e.lat = 1;
    end else if (dvd[31:16] >= dvs) begin
      e.res = {16'hFFFF, 16'h0, 3'b001}; e.lat = 1;
    end else if (dvd[31:16] == 0) begin
      qf = dvd / {16'h0, dvs}; rr = dvd % {16'h0, dvs};
      e.res = {qf[15:0], rr[15:0], 3'b100}; e.lat = 17;
    end else begin
      qf = dvd / {16'h0, dvs};
      rr = (dvd >> AB) % {16'h0, dvs};
      qf = qf & ~((32'd1 << AB) - 1);
      if (rr != 0) qf = qf | (32'd1 << (AB - 1));
      e.res = {qf[15:0], 16'h0, 3'b000}; e.lat = 17 - AB;
    end
    return e;
  endfunction

  function automatic logic [50:0] obs();
    return {quotient, remainder, exact, div_by_zero, overflow};
  endfunction

  // Accept one op (assumes DUT idle) and push its expectation.
  task automatic send(input logic [31:0] dvd, input logic [15:0] dvs);
    @(negedge clk);
    dividend = dvd; divisor = dvs; in_valid = 1'b1;
    exp_q.push_back(model(dvd, dvs));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Cycles from accept edge until out_valid, sampled on negedge; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({in_ready, out_valid, obs()} !== {2'b10, 51'h0}) begin
      n_bad++;
      $display("FAIL reset: got rdy/vld/res=%h want %h", {in_ready, out_valid, obs()}, {2'b10, 51'h0});
    end
  endtask

  task automatic test_op(input string name, input logic [31:0] dvd, input logic [15:0] dvs);
    exp_t e; int lat;
    send(dvd, dvs);
    wait_out(lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
    end
    n_cmp++;
    if (obs() !== e.res) begin
      n_bad++; $display("FAIL %s result: got %h want %h", name, obs(), e.res);
    end
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL %s post-handshake rdy/vld: got %b want 10", name, {in_ready, out_valid});
    end
  endtask

  task automatic test_backpressure();
    exp_t e; int lat;
    out_ready = 1'b0;
    send(32'd1000, 16'd7);
    wait_out(lat);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_bad++; $display("FAIL bp latency: got %0d want %0d", lat, e.lat);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({in_ready, out_valid, obs()} !== {2'b01, e.res}) begin
        n_bad++; $display("FAIL bp hold %0d: got %h want %h", i, {in_ready, out_valid, obs()}, {2'b01, e.res});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL bp release rdy/vld: got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dividend = 32'd1000; divisor = 16'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL midreset rdy/vld: got %b want 10", {in_ready, out_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    test_op("after_reset", 32'd100, 16'd10);
  endtask

  task automatic test_random();
    logic [15:0] dvs, hi;
    for (int i = 0; i < 8; i++) begin
      dvs = 16'($urandom_range(1, 65535));
      hi  = (i % 2 == 0) ? 16'h0 : 16'($urandom % {16'h0, dvs});
      test_op("random", {hi, 16'($urandom)}, dvs);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dividend = '0; divisor = '0;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_op("exact", 32'd1000, 16'd7);
    test_op("approx", 32'h00123456, 16'h0100);
    test_op("approx_even", 32'h00120000, 16'h0100);
    test_op("div0", 32'h0000ABCD, 16'h0);
    test_op("overflow", 32'h00050000, 16'd4);
    test_op("overflow_eq", 32'h0007FFFF, 16'd7);
    test_op("exact_max", 32'h0000FFFF, 16'd1);
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
